// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and default constants for the multi-channel
//               clock-enable generator (clk_div_multi / clk_div_chan).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  // Channel output behaviour at terminal count
  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_TOGGLE = 1'b1
  } mode_e;

  // Default counter width and reset divisor (62.5M -> 1 Hz-ish tick at 62.5 MHz)
  localparam int              CNT_W_DEF   = 28;
  localparam logic [27:0]     DEF_DIV_DEF = 28'h3B9ACA0;

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// Module      : clk_div_chan
// Description : One clock-enable channel. Holds its own counter, divisor and
//               mode. Emits a registered one-cycle tick at terminal count and,
//               in toggle mode, inverts a square-wave level at the same point.
//               Priority: rst > load > sync > count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEF_DIV_DEF),
  parameter bit               DEF_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             load_mode,
  input  logic             sync,
  output logic             tick,
  output logic             level
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;

  // Next-state: a load restarts the channel, sync re-phases it, else count
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    level_d = level_q;
    if (load) begin
      div_d   = load_div;
      mode_d  = mode_e'(load_mode);
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (sync) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (run) begin
      // Equality compare: cnt is always restarted on load, so it never passes div
      if (cnt_q == div_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_q == MODE_TOGGLE) begin
          level_d = ~level_q;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      div_q   <= DEF_DIV;
      mode_q  <= mode_e'(DEF_MODE);
      tick_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      level_q <= level_d;
    end
  end

  assign tick  = tick_q;
  assign level = level_q;

endmodule : clk_div_chan

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module      : clk_div_multi
// Description : Multi-channel programmable clock-enable generator. Decodes
//               configuration writes into per-channel loads, reports accept /
//               reject with one-cycle cfg_ack / cfg_err pulses, and
//               instantiates NUM_CH clk_div_chan channels.
//               Optional macro CLK_DIV_MULTI_SYNC_EN adds a 'sync' input that
//               phase-aligns all channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEF_DIV_DEF),
  parameter bit               DEF_MODE = 1'b0,
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] run,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level
);

  logic              ch_valid;
  logic              sync_all;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] load;

  // Channel index in range? Extra bit keeps the compare correct at NUM_CH = 2^CH_W
  assign ch_valid = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  // Write response: accepted writes ack, out-of-range writes err
  always_comb begin
    ack_d = cfg_we & ch_valid;
    err_d = cfg_we & ~ch_valid;
  end

  // Response pulse registers; reset drops any pending response
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_chan
      assign load[i] = cfg_we && ch_valid && (cfg_ch == CH_W'(i));

      clk_div_chan #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (DEF_DIV),
        .DEF_MODE (DEF_MODE)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .run       (run[i]),
        .load      (load[i]),
        .load_div  (cfg_div),
        .load_mode (cfg_mode),
        .sync      (sync_all),
        .tick      (tick[i]),
        .level     (level[i])
      );
    end
  endgenerate

endmodule : clk_div_multi

`default_nettype wire
